// File: rtl/mod6_gray_seq_checker_if.sv
// mod6_gray_seq_checker_if: code-stream input and check/status outputs of the mod-6 Gray checker.
interface mod6_gray_seq_checker_if #(parameter int ERR_W = 8);
    logic [2:0]       gray_in;
    logic             gray_valid;
    logic             err_clr;
    logic [2:0]       bin_out;
    logic             bin_valid;
    logic             locked;
    logic             seq_err;
    logic             invalid_code;
    logic [ERR_W-1:0] err_count;
    modport master (
        output gray_in, gray_valid, err_clr,
        input  bin_out, bin_valid, locked, seq_err, invalid_code, err_count
    );
    modport slave (
        input  gray_in, gray_valid, err_clr,
        output bin_out, bin_valid, locked, seq_err, invalid_code, err_count
    );
endinterface

// File: rtl/mod6_gray_seq_checker.sv
// mod6_gray_seq_checker: decodes a mod-6 Gray stream, locks onto it and counts sequence errors.
module mod6_gray_seq_checker #(
    parameter int LOCK_CNT    = 3,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mod6_gray_seq_checker_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t           r_state, w_state;
    logic [2:0]       r_prev, w_prev, r_bin, w_bin, w_idx, w_succ;
    logic [GW-1:0]    r_good, w_good;
    logic [BW-1:0]    r_bad, w_bad;
    logic [ERR_W-1:0] r_err, w_err;
    logic             r_bin_valid, w_bin_valid, r_locked;
    logic             r_seq_err, w_seq_err, r_invalid, w_invalid;
    logic             w_legal, w_ok;

    // Plain Gray-to-binary decode; the two illegal codes land on 6 and 7
    assign w_idx   = {bus.gray_in[2], ^bus.gray_in[2:1], ^bus.gray_in};
    assign w_legal = w_idx < 3'd6;
    assign w_succ  = (r_prev == 3'd5) ? 3'd0 : r_prev + 3'd1;
    assign w_ok    = w_legal && (w_idx == w_succ);

    always_comb begin
        w_state     = r_state;
        w_prev      = r_prev;
        w_bin       = r_bin;
        w_good      = r_good;
        w_bad       = r_bad;
        w_bin_valid = 1'b0;
        w_seq_err   = 1'b0;
        w_invalid   = 1'b0;
        if (bus.gray_valid) begin
            w_bin_valid = w_legal;
            w_invalid   = !w_legal;
            w_bin       = w_legal ? w_idx : r_bin;
            w_prev      = w_legal ? w_idx : r_prev;
            case (r_state)
                HUNT: begin
                    if (w_legal) begin
                        w_state = CHECK;
                        w_good  = '0;
                    end
                end
                CHECK: begin
                    if (!w_legal) begin
                        w_state = HUNT;
                    end else if (!w_ok) begin
                        w_good = '0;
                    end else if (r_good == GW'(LOCK_CNT - 1)) begin
                        w_state = LOCKED;
                        w_good  = '0;
                    end else begin
                        w_good = r_good + 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_ok) begin
                        w_bad = '0;
                    end else begin
                        w_seq_err = 1'b1;
                        w_bad     = r_bad + 1'b1;
                        if (r_bad == BW'(UNLOCK_ERRS - 1)) begin
                            w_state = HUNT;
                            w_good  = '0;
                            w_bad   = '0;
                        end
                    end
                end
                default: w_state = HUNT;
            endcase
        end
        // A clear coinciding with an error leaves that error counted
        w_err = bus.err_clr ? ERR_W'(w_seq_err)
              : (w_seq_err && r_err != '1) ? r_err + 1'b1 : r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_prev      <= '0;
            r_bin       <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_err       <= '0;
            r_bin_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_seq_err   <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_prev      <= w_prev;
            r_bin       <= w_bin;
            r_good      <= w_good;
            r_bad       <= w_bad;
            r_err       <= w_err;
            r_bin_valid <= w_bin_valid;
            r_locked    <= (w_state == LOCKED);
            r_seq_err   <= w_seq_err;
            r_invalid   <= w_invalid;
        end
    end

    assign bus.bin_out      = r_bin;
    assign bus.bin_valid    = r_bin_valid;
    assign bus.locked       = r_locked;
    assign bus.seq_err      = r_seq_err;
    assign bus.invalid_code = r_invalid;
    assign bus.err_count    = r_err;
endmodule

// File: tb/tb_mod6_gray_seq_checker.sv
// tb_mod6_gray_seq_checker: directed checks of the mod-6 Gray checker, default and 2-bit error counter.
module tb_mod6_gray_seq_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mod6_gray_seq_checker_if #(.ERR_W(8)) ia ();
    mod6_gray_seq_checker_if #(.ERR_W(2)) ib ();

    mod6_gray_seq_checker #(.ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mod6_gray_seq_checker #(.ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic sa(input logic [2:0] g, input logic v = 1'b1, input logic c = 1'b0);
        ia.gray_in = g;
        ia.gray_valid = v;
        ia.err_clr = c;
        @(posedge clk);
        #1;
        ia.gray_valid = 1'b0;
        ia.err_clr = 1'b0;
    endtask

    task automatic sb(input logic [2:0] g, input logic v = 1'b1, input logic c = 1'b0);
        ib.gray_in = g;
        ib.gray_valid = v;
        ib.err_clr = c;
        @(posedge clk);
        #1;
        ib.gray_valid = 1'b0;
        ib.err_clr = 1'b0;
    endtask

    task automatic ea(input string t, input logic [2:0] b, input logic bv, lk, se, inv,
                      input logic [7:0] ec);
        chk({t, ".bin"}, 32'(ia.bin_out), 32'(b));
        chk({t, ".bv"}, 32'(ia.bin_valid), 32'(bv));
        chk({t, ".lk"}, 32'(ia.locked), 32'(lk));
        chk({t, ".se"}, 32'(ia.seq_err), 32'(se));
        chk({t, ".inv"}, 32'(ia.invalid_code), 32'(inv));
        chk({t, ".ec"}, 32'(ia.err_count), 32'(ec));
    endtask

    task automatic eb(input string t, input logic lk, se, input logic [1:0] ec);
        chk({t, ".lk"}, 32'(ib.locked), 32'(lk));
        chk({t, ".se"}, 32'(ib.seq_err), 32'(se));
        chk({t, ".ec"}, 32'(ib.err_count), 32'(ec));
    endtask

    initial begin
        ia.gray_in = 3'b000; ia.gray_valid = 1'b0; ia.err_clr = 1'b0;
        ib.gray_in = 3'b000; ib.gray_valid = 1'b0; ib.err_clr = 1'b0;
        @(posedge clk);
        #1;
        ea("rst", 3'd0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        // acquire lock
        sa(3'b000); ea("l0", 3'd0, 1, 0, 0, 0, 8'd0);
        sa(3'b001); ea("l1", 3'd1, 1, 0, 0, 0, 8'd0);
        sa(3'b011); ea("l2", 3'd2, 1, 0, 0, 0, 8'd0);
        sa(3'b010); ea("l3", 3'd3, 1, 1, 0, 0, 8'd0);
        // run through the 5->0 wrap
        sa(3'b110); ea("w4", 3'd4, 1, 1, 0, 0, 8'd0);
        sa(3'b111); ea("w5", 3'd5, 1, 1, 0, 0, 8'd0);
        sa(3'b000); ea("w0", 3'd0, 1, 1, 0, 0, 8'd0);
        sa(3'b001); ea("w1", 3'd1, 1, 1, 0, 0, 8'd0);
        // single error then repeats forcing unlock
        sa(3'b110); ea("e1", 3'd4, 1, 1, 1, 0, 8'd1);
        sa(3'b111); ea("e2", 3'd5, 1, 1, 0, 0, 8'd1);
        sa(3'b000); ea("e3", 3'd0, 1, 1, 0, 0, 8'd1);
        sa(3'b000); ea("e4", 3'd0, 1, 1, 1, 0, 8'd2);
        sa(3'b000); ea("e5", 3'd0, 1, 0, 1, 0, 8'd3);
        // relock from HUNT
        sa(3'b001); ea("r1", 3'd1, 1, 0, 0, 0, 8'd3);
        sa(3'b011); ea("r2", 3'd2, 1, 0, 0, 0, 8'd3);
        sa(3'b010); ea("r3", 3'd3, 1, 0, 0, 0, 8'd3);
        sa(3'b110); ea("r4", 3'd4, 1, 1, 0, 0, 8'd3);
        // illegal code while locked; prev stays at 4
        sa(3'b100); ea("i1", 3'd4, 0, 1, 1, 1, 8'd4);
        sa(3'b111); ea("i2", 3'd5, 1, 1, 0, 0, 8'd4);
        // gray_valid every other cycle, idle codes are ignored
        sa(3'b000);       ea("t0", 3'd0, 1, 1, 0, 0, 8'd4);
        sa(3'b111, 1'b0); ea("t1", 3'd0, 0, 1, 0, 0, 8'd4);
        sa(3'b001);       ea("t2", 3'd1, 1, 1, 0, 0, 8'd4);
        sa(3'b110, 1'b0); ea("t3", 3'd1, 0, 1, 0, 0, 8'd4);
        sa(3'b011);       ea("t4", 3'd2, 1, 1, 0, 0, 8'd4);
        sa(3'b100, 1'b0); ea("t5", 3'd2, 0, 1, 0, 0, 8'd4);
        sa(3'b000, 1'b0, 1'b1); ea("clr", 3'd2, 0, 1, 0, 0, 8'd0);
        // asynchronous reset between edges
        sa(3'b010); ea("pre", 3'd3, 1, 1, 0, 0, 8'd0);
        #2 rst = 1'b1;
        #1;
        ea("arst", 3'd0, 0, 0, 0, 0, 8'd0);
        #1 rst = 1'b0;
        // HUNT/CHECK behaviour, including a non-successor restarting the count
        sa(3'b011); ea("h1", 3'd2, 1, 0, 0, 0, 8'd0);
        sa(3'b010); ea("h2", 3'd3, 1, 0, 0, 0, 8'd0);
        sa(3'b101); ea("h3", 3'd3, 0, 0, 0, 1, 8'd0);
        sa(3'b100); ea("h4", 3'd3, 0, 0, 0, 1, 8'd0);
        sa(3'b110); ea("c1", 3'd4, 1, 0, 0, 0, 8'd0);
        sa(3'b111); ea("c2", 3'd5, 1, 0, 0, 0, 8'd0);
        sa(3'b000); ea("c3", 3'd0, 1, 0, 0, 0, 8'd0);
        sa(3'b010); ea("c4", 3'd3, 1, 0, 0, 0, 8'd0);
        sa(3'b110); ea("c5", 3'd4, 1, 0, 0, 0, 8'd0);
        sa(3'b111); ea("c6", 3'd5, 1, 0, 0, 0, 8'd0);
        sa(3'b000); ea("c7", 3'd0, 1, 1, 0, 0, 8'd0);
        // 2-bit error counter saturation
        sb(3'b000); sb(3'b001); sb(3'b011);
        sb(3'b010); eb("bl", 1, 0, 2'd0);
        sb(3'b000); eb("b1", 1, 1, 2'd1);
        sb(3'b001); eb("b1o", 1, 0, 2'd1);
        sb(3'b000); eb("b2", 1, 1, 2'd2);
        sb(3'b001);
        sb(3'b000); eb("b3", 1, 1, 2'd3);
        sb(3'b001);
        sb(3'b000); eb("b4", 1, 1, 2'd3);
        sb(3'b001);
        sb(3'b000); eb("b5", 1, 1, 2'd3);
        sb(3'b001);
        sb(3'b000, 1'b1, 1'b1); eb("bclr", 1, 1, 2'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
